// File: rtl/register_file_mp.sv
// Multi-port integer register file (NRD async reads, two sync writes) with a per-register busy scoreboard.
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module register_file_mp #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we3,
  input  logic [AW-1:0]        wa3,
  input  logic [XLEN-1:0]      wd3,
  input  logic                 we4,
  input  logic [AW-1:0]        wa4,
  input  logic [XLEN-1:0]      wd4,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*XLEN-1:0]  rd,
  output logic [NRD-1:0]       busy,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr
);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy_q;

  // Storage and scoreboard; entry 0 is never written so x0 stays zero and never busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        mem[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        // Port 3 wins a same-address conflict; port 4 is dropped.
        if (we3 && (wa3 == AW'(r))) begin
          mem[r] <= wd3;
        end else if (we4 && (wa4 == AW'(r))) begin
          mem[r] <= wd4;
        end
        // A new producer issued on the same edge as a writeback keeps the register busy.
        if (sb_set && (sb_addr == AW'(r))) begin
          busy_q[r] <= 1'b1;
        end else if ((we3 && (wa3 == AW'(r))) || (we4 && (wa4 == AW'(r)))) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          live;

    assign a    = ra[i*AW +: AW];
    assign live = !rst && (a != '0);

`ifdef RF_BYPASS_EN
    logic hit3;
    logic hit4;

    assign hit3 = we3 && (wa3 == a);
    assign hit4 = we4 && (wa4 == a);

    // Forward in-flight write data; a register being written has no outstanding producer.
    assign rd[i*XLEN +: XLEN] = !live ? '0 : hit3 ? wd3 : hit4 ? wd4 : mem[a];
    assign busy[i]            = live && busy_q[a] && !hit3 && !hit4;
`else
    assign rd[i*XLEN +: XLEN] = live ? mem[a] : '0;
    assign busy[i]            = live && busy_q[a];
`endif
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: reset, directed table, forwarding/reset corners,
// random traffic against a behavioural model, and a 16x64 3-read-port sweep.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we3, we4, sb_set;
  logic [4:0]  wa3, wa4, sb_addr;
  logic [31:0] wd3, wd4;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  busy;

  logic         we3b, we4b, sb_setb;
  logic [3:0]   wa3b, wa4b, sb_addrb;
  logic [63:0]  wd3b, wd4b;
  logic [11:0]  rab;
  logic [191:0] rdb;
  logic [2:0]   busyb;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_m [32];
  logic        busy_m [32];

  always #5 clk = ~clk;

  register_file_mp dut (
    .clk(clk), .rst(rst),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .ra(ra), .rd(rd), .busy(busy),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  register_file_mp #(.XLEN(64), .NREG(16), .NRD(3)) dut6 (
    .clk(clk), .rst(rst),
    .we3(we3b), .wa3(wa3b), .wd3(wd3b),
    .we4(we4b), .wa4(wa4b), .wd4(wd4b),
    .ra(rab), .rd(rdb), .busy(busyb),
    .sb_set(sb_setb), .sb_addr(sb_addrb)
  );

  typedef struct {
    logic        we3; logic [4:0] wa3; logic [31:0] wd3;
    logic        we4; logic [4:0] wa4; logic [31:0] wd4;
    logic        sb_set; logic [4:0] sb_addr;
    logic [4:0]  ra0, ra1;
    logic [31:0] rd0, rd1;
    logic        b0, b1;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mem_m[r]  = '0;
      busy_m[r] = 1'b0;
    end
  endtask

  // Register-file rules applied once per rising edge.
  task automatic model_update();
    if (rst) return;
    if (we4 && wa4 != 0) mem_m[wa4] = wd4;
    if (we3 && wa3 != 0) mem_m[wa3] = wd3;
    if (we3) busy_m[wa3] = 1'b0;
    if (we4) busy_m[wa4] = 1'b0;
    if (sb_set) busy_m[sb_addr] = 1'b1;
    busy_m[0] = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (rst || a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (we3 && wa3 == a) return wd3;
    if (we4 && wa4 == a) return wd4;
`endif
    return mem_m[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (rst || a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if ((we3 && wa3 == a) || (we4 && wa4 == a)) return 1'b0;
`endif
    return busy_m[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    we3 = 0; wa3 = '0; wd3 = '0;
    we4 = 0; wa4 = '0; wd4 = '0;
    sb_set = 0; sb_addr = '0;
  endtask

  task automatic check_ports(input string name);
    for (int i = 0; i < 2; i++) begin
      chk({name, "_rd"}, 64'(rd[i*32 +: 32]), 64'(exp_rd(ra[i*5 +: 5])));
      chk({name, "_busy"}, 64'(busy[i]), 64'(exp_busy(ra[i*5 +: 5])));
    end
  endtask

  initial begin
    idle();
    ra = '0; rst = 1'b1;
    we3b = 0; wa3b = '0; wd3b = '0; we4b = 0; wa4b = '0; wd4b = '0;
    sb_setb = 0; sb_addrb = '0; rab = '0;
    model_reset();

    vecs[0] = '{1, 5'd1, 32'hAAAAAAAA, 0, 5'd0, 32'h0, 0, 5'd0, 5'd1, 5'd0, 32'hAAAAAAAA, 32'h0, 0, 0};
    vecs[1] = '{1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd1, 32'h0, 32'hAAAAAAAA, 0, 0};
    vecs[2] = '{1, 5'd5, 32'h11111111, 1, 5'd5, 32'h22222222, 0, 5'd0, 5'd5, 5'd5, 32'h11111111, 32'h11111111, 0, 0};
    vecs[3] = '{1, 5'd5, 32'h11111111, 1, 5'd6, 32'h22222222, 0, 5'd0, 5'd6, 5'd5, 32'h22222222, 32'h11111111, 0, 0};
    vecs[4] = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd7, 5'd7, 5'd6, 32'h0, 32'h22222222, 1, 0};
    vecs[5] = '{0, 5'd0, 32'h0, 1, 5'd7, 32'hDEADBEEF, 0, 5'd0, 5'd7, 5'd1, 32'hDEADBEEF, 32'hAAAAAAAA, 0, 0};
    vecs[6] = '{1, 5'd7, 32'hCAFEF00D, 0, 5'd0, 32'h0, 1, 5'd7, 5'd7, 5'd1, 32'hCAFEF00D, 32'hAAAAAAAA, 1, 0};
    vecs[7] = '{0, 5'd0, 32'h0, 1, 5'd7, 32'h12345678, 0, 5'd0, 5'd7, 5'd5, 32'h12345678, 32'h11111111, 0, 0};
    vecs[8] = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd7, 32'h0, 32'h12345678, 1, 0};
    vecs[9] = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 0, 1};

    // Reset: outputs zero while held, and every register reads zero after release.
    repeat (3) @(posedge clk);
    ra = {5'd3, 5'd1};
    #1;
    chk("rst_hold_rd", 64'(rd), 64'h0);
    chk("rst_hold_busy", 64'(busy), 64'h0);
    #2 rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      ra = {5'(r), 5'(r)};
      #1;
      chk("rst_rd", 64'(rd), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
    end

    // Directed table: apply writes/sets on one edge, read back after it.
    @(posedge clk); #1;
    foreach (vecs[k]) begin
      we3 = vecs[k].we3; wa3 = vecs[k].wa3; wd3 = vecs[k].wd3;
      we4 = vecs[k].we4; wa4 = vecs[k].wa4; wd4 = vecs[k].wd4;
      sb_set = vecs[k].sb_set; sb_addr = vecs[k].sb_addr;
      tick();
      idle();
      ra = {vecs[k].ra1, vecs[k].ra0};
      #1;
      chk("tbl_rd0", 64'(rd[31:0]), 64'(vecs[k].rd0));
      chk("tbl_rd1", 64'(rd[63:32]), 64'(vecs[k].rd1));
      chk("tbl_busy0", 64'(busy[0]), 64'(vecs[k].b0));
      chk("tbl_busy1", 64'(busy[1]), 64'(vecs[k].b1));
    end

    // Same-cycle read of a register being written.
    we3 = 1; wa3 = 5'd3; wd3 = 32'h0BADF00D;
    tick();
    idle();
    ra = {5'd0, 5'd3};
    we3 = 1; wa3 = 5'd3; wd3 = 32'hDEADBEEF;
    #1;
`ifdef RF_BYPASS_EN
    chk("fwd_before", 64'(rd[31:0]), 64'hDEADBEEF);
`else
    chk("fwd_before", 64'(rd[31:0]), 64'h0BADF00D);
`endif
    tick();
    idle();
    #1;
    chk("fwd_after", 64'(rd[31:0]), 64'hDEADBEEF);

    // Reset asserted mid-cycle while a write is pending: nothing lands, state clears.
    we3 = 1; wa3 = 5'd3; wd3 = 32'h55555555;
    ra = {5'd1, 5'd3};
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_rd0", 64'(rd[31:0]), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    idle();
    #1;
    chk("midrst_x3", 64'(rd[31:0]), 64'h0);
    chk("midrst_x1", 64'(rd[63:32]), 64'h0);
    ra = {5'd9, 5'd7};
    #1;
    chk("midrst_busy_clr", 64'(busy), 64'h0);

    // Random traffic against the model; addresses biased to a small range to force hits.
    @(posedge clk); #1;
    for (int n = 0; n < 400; n++) begin
      we3 = 1'($urandom_range(0, 1)); wa3 = 5'($urandom_range(0, 7)); wd3 = $urandom;
      we4 = 1'($urandom_range(0, 1)); wa4 = 5'($urandom_range(0, 7)); wd4 = $urandom;
      sb_set = ($urandom_range(0, 2) == 0); sb_addr = 5'($urandom_range(0, 7));
      ra[4:0] = ($urandom_range(0, 3) == 0) ? wa3 : 5'($urandom_range(0, 31) & 5'h0F);
      ra[9:5] = ($urandom_range(0, 3) == 0) ? wa4 : 5'($urandom_range(0, 7));
      #1;
      check_ports("rnd");
      tick();
    end
    idle();

    // Wider/smaller configuration: write r*0x0101 to every register, read on all 3 ports.
    for (int r = 0; r < 16; r++) begin
      if (r % 2 == 0) begin
        we3b = 1; wa3b = 4'(r); wd3b = (r == 0) ? '1 : 64'(r * 32'h0101); we4b = 0;
      end else begin
        we4b = 1; wa4b = 4'(r); wd4b = 64'(r * 32'h0101); we3b = 0;
      end
      @(posedge clk); #1;
    end
    we3b = 0; we4b = 0;
    for (int r = 0; r < 16; r++) begin
      int a [3];
      a[0] = r; a[1] = (r + 1) % 16; a[2] = (r + 5) % 16;
      rab = {4'(a[2]), 4'(a[1]), 4'(a[0])};
      #1;
      for (int p = 0; p < 3; p++) begin
        chk("sweep_rd", rdb[p*64 +: 64], 64'(a[p] * 32'h0101));
      end
      chk("sweep_busy", 64'(busyb), 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
